// File: rtl/uart_lock_cmd_rx_if.sv
// Line-side and decoded-output signals of the UART lock command receiver.
// Ports: rx_pin (line in), lock_open, rx_byte, rx_valid, frame_err (outputs).
interface uart_lock_cmd_rx_if;
  logic       rx_pin;
  logic       lock_open;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  modport master (
    output rx_pin,
    input  lock_open,
    input  rx_byte,
    input  rx_valid,
    input  frame_err
  );

  modport slave (
    input  rx_pin,
    output lock_open,
    output rx_byte,
    output rx_valid,
    output frame_err
  );
endinterface

// File: rtl/uart_lock_cmd_rx.sv
// 8N1 UART receiver + single-byte command decoder driving the lock position.
// Ports: clk, rst (sync, active-high), bus (slave: rx_pin in; lock_open,
// rx_byte, rx_valid, frame_err out). Optional PIN gate: UART_LOCK_PIN_EN.
module uart_lock_cmd_rx #(
  parameter int CLK_FREQ         = 50000000,
  parameter int BAUD             = 9600,
  parameter int AUTO_LOCK_CYCLES = 250000000
`ifdef UART_LOCK_PIN_EN
  ,
  parameter logic [31:0] PIN_CODE = 32'h31323334
`endif
) (
  input logic              clk,
  input logic              rst,
  uart_lock_cmd_rx_if.slave bus
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CCW  = $clog2(CPB + 1);

  localparam logic [CCW-1:0] BIT_LAST  = CCW'(CPB - 1);
  localparam logic [CCW-1:0] HALF_LAST =
    (HALF > 0) ? CCW'(HALF - 1) : '0;

  localparam bit TMR_EN = (AUTO_LOCK_CYCLES != 0);
  localparam int TW =
    TMR_EN ? $clog2(AUTO_LOCK_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMR_LAST =
    TMR_EN ? TW'(AUTO_LOCK_CYCLES - 1) : '0;
  localparam logic [TW-1:0] TMR_MAX = '1;

  localparam logic [7:0] CMD_A = 8'h41;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_T = 8'h54;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } rx_state_t;

  rx_state_t      state, state_n;
  logic [1:0]     sync;
  logic           line;
  logic [CCW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]     bit_cnt, bit_cnt_n;
  logic [7:0]     shreg, shreg_n;
  logic [7:0]     byte_q, byte_n;
  logic           valid_q, valid_n;
  logic           ferr_q, ferr_n;
  logic           lock_q, lock_n;
  logic [TW-1:0]  tmr_q, tmr_n;
  logic           open_ok;
`ifdef UART_LOCK_PIN_EN
  logic [31:0]    hist_q, hist_n;
`endif

  assign line = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= 2'b11;
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      lock_q  <= 1'b0;
      tmr_q   <= '0;
    end else begin
      sync    <= {sync[0], bus.rx_pin};
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      byte_q  <= byte_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
      lock_q  <= lock_n;
      tmr_q   <= tmr_n;
    end
  end

`ifdef UART_LOCK_PIN_EN
  always_ff @(posedge clk) begin
    if (rst) hist_q <= '0;
    else     hist_q <= hist_n;
  end
`endif

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    byte_n    = byte_q;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    unique case (state)
      S_IDLE: begin
        clk_cnt_n = '0;
        bit_cnt_n = '0;
        if (!line) state_n = S_START;
      end
      S_START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_n = '0;
          // A start bit that is high at mid-bit was a glitch
          state_n   = line ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n = '0;
          shreg_n   = {line, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = S_STOP;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_n = '0;
          state_n   = S_IDLE;
          if (line) begin
            byte_n  = shreg;
            valid_n = 1'b1;
          end else begin
            ferr_n  = 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    lock_n  = lock_q;
    tmr_n   = tmr_q;
`ifdef UART_LOCK_PIN_EN
    hist_n  = hist_q;
    open_ok = (hist_q == PIN_CODE);
`else
    open_ok = 1'b1;
`endif
    // Timeout path first so a same-cycle command overrides it
    if (!lock_q) begin
      tmr_n = '0;
    end else if (TMR_EN) begin
      if (tmr_q == TMR_LAST) begin
        lock_n = 1'b0;
        tmr_n  = '0;
      end else if (tmr_q != TMR_MAX) begin
        tmr_n = tmr_q + 1'b1;
      end
    end
    if (valid_q) begin
`ifdef UART_LOCK_PIN_EN
      hist_n = {hist_q[23:0], byte_q};
`endif
      unique case (1'b1)
        (byte_q == CMD_A): begin
          if (open_ok) begin
            lock_n = 1'b1;
            tmr_n  = '0;
`ifdef UART_LOCK_PIN_EN
            hist_n = '0;
`endif
          end
        end
        (byte_q == CMD_C): begin
          lock_n = 1'b0;
          tmr_n  = '0;
        end
        (byte_q == CMD_T): begin
          if (lock_q) begin
            lock_n = 1'b0;
            tmr_n  = '0;
          end else if (open_ok) begin
            lock_n = 1'b1;
            tmr_n  = '0;
`ifdef UART_LOCK_PIN_EN
            hist_n = '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.lock_open = lock_q;
  assign bus.rx_byte   = byte_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;

endmodule
